// File: rtl/mbox_pkg.sv
// Shared mailbox address map, command/flag encodings and host FSM state codes
// for both sides of the cracker mailbox.
package mbox_pkg;

  localparam logic [7:0] MBX_CMD     = 8'd0;
  localparam logic [7:0] MBX_FLAG    = 8'd1;
  localparam logic [7:0] MBX_KEY_HI  = 8'd2;
  localparam logic [7:0] MBX_KEY_MID = 8'd3;
  localparam logic [7:0] MBX_KEY_LO  = 8'd4;

  localparam logic [7:0] CMD_GO   = 8'hFF;
  localparam logic [7:0] CMD_IDLE = 8'h00;
  localparam logic [7:0] FLAG_OK  = 8'hFF;

  localparam int unsigned ST_W  = 4;
  localparam int unsigned KEY_W = 24;

  typedef logic [ST_W-1:0] host_state_t;

  localparam host_state_t ST_IDLE = 4'd0;
  localparam host_state_t ST_CLR  = 4'd1;
  localparam host_state_t ST_CMD  = 4'd2;
  localparam host_state_t ST_POLL = 4'd3;
  localparam host_state_t ST_CHK  = 4'd4;
  localparam host_state_t ST_RDK0 = 4'd5;
  localparam host_state_t ST_RDK1 = 4'd6;
  localparam host_state_t ST_RDK2 = 4'd7;
  localparam host_state_t ST_REL  = 4'd8;
  localparam host_state_t ST_DONE = 4'd9;

endpackage

// File: rtl/mbox_host.sv
// Initiator side of the cracker mailbox: posts a start command, polls the
// result flag with a timeout, fetches the 24-bit key and releases the responder.
module mbox_host
  import mbox_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timed_out,
  output logic [KEY_W-1:0] key,
  output logic [7:0]       mbx_addr,
  output logic [7:0]       mbx_wrdata,
  output logic             mbx_wren,
  input  logic [7:0]       mbx_rddata
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  host_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  logic             to_q, to_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wrdata_q, wrdata_d;
  logic             wren_q, wren_d;

  // Next state, result capture and registered mailbox outputs for the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    found_d  = found_q;
    to_d     = to_q;
    key_d    = key_q;
    addr_d   = MBX_CMD;
    wrdata_d = CMD_IDLE;
    wren_d   = 1'b0;

    if ((state_q == ST_POLL || state_q == ST_CHK) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLR;
          found_d = 1'b0;
          to_d    = 1'b0;
          key_d   = '0;
        end
      end
      ST_CLR:  state_d = ST_CMD;
      ST_CMD: begin
        cnt_d   = '0;
        state_d = ST_POLL;
      end
      ST_POLL: begin
        if (abort) begin
          found_d = 1'b0;
          to_d    = 1'b0;
          state_d = ST_REL;
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (mbx_rddata == FLAG_OK) begin
          state_d = ST_RDK0;
        end else if (abort) begin
          found_d = 1'b0;
          to_d    = 1'b0;
          state_d = ST_REL;
        end else if (cnt_q >= CNT_LIM) begin
          to_d    = 1'b1;
          state_d = ST_REL;
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_RDK0: begin
        key_d[23:16] = mbx_rddata;
        state_d      = ST_RDK1;
      end
      ST_RDK1: begin
        key_d[15:8] = mbx_rddata;
        state_d     = ST_RDK2;
      end
      ST_RDK2: begin
        key_d[7:0] = mbx_rddata;
        found_d    = 1'b1;
        state_d    = ST_REL;
      end
      ST_REL:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // CHK presents the key-high address speculatively so RDK0 sees its data
    case (state_d)
      ST_CLR: begin
        wren_d   = 1'b1;
        addr_d   = MBX_FLAG;
        wrdata_d = CMD_IDLE;
      end
      ST_CMD: begin
        wren_d   = 1'b1;
        addr_d   = MBX_CMD;
        wrdata_d = CMD_GO;
      end
      ST_POLL: addr_d = MBX_FLAG;
      ST_CHK:  addr_d = MBX_KEY_HI;
      ST_RDK0: addr_d = MBX_KEY_MID;
      ST_RDK1: addr_d = MBX_KEY_LO;
      ST_REL: begin
        wren_d   = 1'b1;
        addr_d   = MBX_CMD;
        wrdata_d = CMD_IDLE;
      end
      default: addr_d = MBX_CMD;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      to_q     <= 1'b0;
      key_q    <= '0;
      addr_q   <= MBX_CMD;
      wrdata_q <= CMD_IDLE;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      to_q     <= to_d;
      key_q    <= key_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign timed_out  = to_q;
  assign key        = key_q;
  assign mbx_addr   = addr_q;
  // A reset cycle must never write the mailbox, even mid-write
  assign mbx_wren   = wren_q & ~rst;
  assign mbx_wrdata = rst ? CMD_IDLE : wrdata_q;

endmodule

// File: tb/tb_mbox_host.sv
// Directed bench for mbox_host against a registered-read mailbox RAM and a
// scripted responder; a second instance runs with a short timeout.
module tb_mbox_host;
  import mbox_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, abort = 1'b0, sel = 1'b0;
  logic [7:0] rddata;

  logic busy_a, done_a, found_a, to_a, wren_a;
  logic busy_b, done_b, found_b, to_b, wren_b;
  logic [23:0] key_a, key_b;
  logic [7:0] addr_a, wd_a, addr_b, wd_b;
  logic start_a, start_b, abort_a, abort_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign abort_a = abort & ~sel;
  assign abort_b = abort & sel;

  mbox_host #(.TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .found(found_a), .timed_out(to_a), .key(key_a),
    .mbx_addr(addr_a), .mbx_wrdata(wd_a), .mbx_wren(wren_a), .mbx_rddata(rddata));

  mbox_host #(.TIMEOUT_CYCLES(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .found(found_b), .timed_out(to_b), .key(key_b),
    .mbx_addr(addr_b), .mbx_wrdata(wd_b), .mbx_wren(wren_b), .mbx_rddata(rddata));

  logic busy, done, found, timed_out, mbx_wren;
  logic [23:0] key;
  logic [7:0] mbx_addr, mbx_wrdata;
  assign busy       = sel ? busy_b : busy_a;
  assign done       = sel ? done_b : done_a;
  assign found      = sel ? found_b : found_a;
  assign timed_out  = sel ? to_b : to_a;
  assign key        = sel ? key_b : key_a;
  assign mbx_addr   = sel ? addr_b : addr_a;
  assign mbx_wrdata = sel ? wd_b : wd_a;
  assign mbx_wren   = sel ? wren_b : wren_a;

  // Mailbox RAM plus responder: mode 0 silent, 1 flag after 20 cycles,
  // 2 writes 0xFE first then 0xFF, 3 flags immediately on the start command
  logic [7:0] mem [0:255];
  int resp_mode = 0;
  logic armed = 1'b0;
  int rcnt = 0;
  int n_done = 0, n_cmd = 0, n_rel = 0;
  logic pre_en = 1'b0;
  logic [7:0] pre_addr = 8'h00, pre_data = 8'h00;

  always @(posedge clk) begin
    rddata <= mem[mbx_addr];
    if (mbx_wren) mem[mbx_addr] <= mbx_wrdata;
    if (pre_en) mem[pre_addr] <= pre_data;
    if (done) n_done <= n_done + 1;
    if (mbx_wren && mbx_addr == MBX_CMD && mbx_wrdata == CMD_GO) n_cmd <= n_cmd + 1;
    if (mbx_wren && mbx_addr == MBX_CMD && mbx_wrdata == CMD_IDLE) n_rel <= n_rel + 1;
    if (mbx_wren && mbx_addr == MBX_CMD && mbx_wrdata == CMD_GO) begin
      armed <= 1'b1;
      rcnt  <= 0;
      if (resp_mode == 3) mem[MBX_FLAG] <= FLAG_OK;
    end else if (armed) begin
      rcnt <= rcnt + 1;
      if (rcnt == 5 && resp_mode == 2) mem[MBX_FLAG] <= 8'hFE;
      if (rcnt == 19 && (resp_mode == 1 || resp_mode == 2)) mem[MBX_FLAG] <= FLAG_OK;
      if (mbx_wren && mbx_addr == MBX_CMD && mbx_wrdata == CMD_IDLE) armed <= 1'b0;
    end
  end

  int n_vec = 0, n_miss = 0;

  task automatic mem_put(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic put_key(input logic [23:0] k);
    mem_put(MBX_KEY_HI, k[23:16]);
    mem_put(MBX_KEY_MID, k[15:8]);
    mem_put(MBX_KEY_LO, k[7:0]);
  endtask

  // Start sampled at edge 0; returns the cycle index carrying done, -1 if none
  task automatic run_start(input int budget, output int done_cyc);
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= budget && done_cyc < 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cyc = c;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, found, timed_out, key, mbx_wren, mbx_addr, mbx_wrdata} !== 44'h0) begin
      n_miss++;
      $display("FAIL reset_outputs: got %h want 0",
               {busy, done, found, timed_out, key, mbx_wren, mbx_addr, mbx_wrdata});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cycle_map;
    logic [19:0] exp_t [0:9];
    logic [19:0] got;
    exp_t = '{ {1'b1, 8'h01, 8'h00, 3'b100}, {1'b1, 8'h00, 8'hFF, 3'b100},
               {1'b0, 8'h01, 8'h00, 3'b100}, {1'b0, 8'h02, 8'h00, 3'b100},
               {1'b0, 8'h03, 8'h00, 3'b100}, {1'b0, 8'h04, 8'h00, 3'b100},
               {1'b0, 8'h00, 8'h00, 3'b100}, {1'b1, 8'h00, 8'h00, 3'b101},
               {1'b0, 8'h00, 8'h00, 3'b111}, {1'b0, 8'h00, 8'h00, 3'b001} };
    put_key(24'hA1B2C3);
    resp_mode = 3;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      got = {mbx_wren, mbx_addr, mbx_wrdata, busy, done, found};
      n_vec++;
      if (got !== exp_t[c-1]) begin
        n_miss++;
        $display("FAIL cycle_map_c%0d: got %h want %h", c, got, exp_t[c-1]);
      end
    end
    n_vec++;
    if (key !== 24'hA1B2C3) begin
      n_miss++;
      $display("FAIL cycle_map_key: got %h want a1b2c3", key);
    end
  endtask

  task automatic test_happy;
    int dc, d0;
    put_key(24'h123456);
    resp_mode = 1;
    d0 = n_done;
    run_start(100, dc);
    n_vec++;
    if (dc !== 29) begin n_miss++; $display("FAIL happy_latency: got %0d want 29", dc); end
    n_vec++;
    if ({found, timed_out, key} !== {2'b10, 24'h123456}) begin
      n_miss++;
      $display("FAIL happy_result: got %h want %h", {found, timed_out, key}, {2'b10, 24'h123456});
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (n_done - d0 !== 1) begin n_miss++; $display("FAIL happy_done_count: got %0d want 1", n_done - d0); end
    n_vec++;
    if (mem[MBX_CMD] !== CMD_IDLE) begin n_miss++; $display("FAIL happy_addr0: got %h want 00", mem[MBX_CMD]); end
  endtask

  task automatic test_stale_flag;
    int dc;
    sel = 1'b1;
    resp_mode = 0;
    mem_put(MBX_FLAG, 8'hFF);
    run_start(100, dc);
    n_vec++;
    if (dc !== 20) begin n_miss++; $display("FAIL stale_latency: got %0d want 20", dc); end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({found, timed_out} !== 2'b01) begin
      n_miss++;
      $display("FAIL stale_result: got found=%b timed_out=%b want found=0 timed_out=1", found, timed_out);
    end
    n_vec++;
    if ({mem[MBX_CMD], mem[MBX_FLAG]} !== 16'h0000) begin
      n_miss++;
      $display("FAIL stale_mailbox: got %h want 0000", {mem[MBX_CMD], mem[MBX_FLAG]});
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int dc, r0;
    resp_mode = 0;
    r0 = n_rel;
    @(negedge clk);
    start = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    dc = -1;
    for (int c = 1; c <= 3 && dc < 0; c++) begin
      @(negedge clk);
      if (done) dc = c;
    end
    abort = 1'b0;
    n_vec++;
    if (dc < 1) begin n_miss++; $display("FAIL abort_done: got %0d want 1..3", dc); end
    n_vec++;
    if ({found, timed_out} !== 2'b00) begin
      n_miss++;
      $display("FAIL abort_result: got %b want 00", {found, timed_out});
    end
    @(negedge clk);
    n_vec++;
    if (n_rel - r0 !== 1) begin n_miss++; $display("FAIL abort_rel: got %0d want 1", n_rel - r0); end
  endtask

  task automatic test_back_to_back;
    int c0, d0, dc;
    resp_mode = 3;
    c0 = n_cmd;
    d0 = n_done;
    dc = -1;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      start = (c == 4 || c == 8);
      if (done && dc < 0) dc = c;
    end
    start = 1'b0;
    n_vec++;
    if (dc !== 9) begin n_miss++; $display("FAIL b2b_latency: got %0d want 9", dc); end
    n_vec++;
    if ({n_cmd - c0, n_done - d0} !== {32'd1, 32'd1}) begin
      n_miss++;
      $display("FAIL b2b_counts: got cmd=%0d done=%0d want 1 1", n_cmd - c0, n_done - d0);
    end
    n_vec++;
    if (busy !== 1'b0) begin n_miss++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    int dc;
    put_key(24'h9ABCDE);
    resp_mode = 3;
    @(negedge clk);
    start = 1'b1;
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (mbx_wren !== 1'b0) begin n_miss++; $display("FAIL rstmid_wren_now: got %b want 0", mbx_wren); end
    @(negedge clk);
    n_vec++;
    if ({busy, done, found, timed_out, key, mbx_wren, mbx_addr, mbx_wrdata} !== 44'h0) begin
      n_miss++;
      $display("FAIL rstmid_outputs: got %h want 0",
               {busy, done, found, timed_out, key, mbx_wren, mbx_addr, mbx_wrdata});
    end
    n_vec++;
    if (mem[MBX_CMD] !== CMD_GO) begin n_miss++; $display("FAIL rstmid_no_rel: got %h want ff", mem[MBX_CMD]); end
    rst = 1'b0;
    run_start(40, dc);
    n_vec++;
    if (dc !== 9) begin n_miss++; $display("FAIL rstmid_restart_latency: got %0d want 9", dc); end
    n_vec++;
    if ({found, key} !== {1'b1, 24'h9ABCDE}) begin
      n_miss++;
      $display("FAIL rstmid_restart_key: got %h want %h", {found, key}, {1'b1, 24'h9ABCDE});
    end
    @(negedge clk);
  endtask

  task automatic test_flag_exact;
    int dc;
    put_key(24'h654321);
    resp_mode = 2;
    run_start(100, dc);
    n_vec++;
    if (dc !== 29) begin n_miss++; $display("FAIL flag_exact_latency: got %0d want 29", dc); end
    n_vec++;
    if ({found, timed_out, key} !== {2'b10, 24'h654321}) begin
      n_miss++;
      $display("FAIL flag_exact_result: got %h want %h", {found, timed_out, key}, {2'b10, 24'h654321});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_cycle_map;
    test_happy;
    test_stale_flag;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    test_flag_exact;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
